// File: rtl/weight_pkg.sv
// Shared types and sizing for the weight streamer: layer geometry, beat counts
// and the packed row type handed to the neuron array.
package weight_pkg;

  localparam int NUM_NEURONS = 128;
  localparam int IMG_SZ      = 784;
  localparam int OUTPUT_SZ   = 10;
  localparam int LANES       = 8;

  localparam int BEATS0  = NUM_NEURONS / LANES;
  localparam int BEATS1  = (OUTPUT_SZ + LANES - 1) / LANES;
  localparam int BEAT_W  = LANES * 32;
  localparam int ROW_W   = NUM_NEURONS * 32;
  localparam int BEAT_CW = $clog2(BEATS0);
  localparam int ROW_CW  = $clog2(IMG_SZ + 1);
  localparam int IDX_W   = $clog2(IMG_SZ);

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {L_HID, L_OUT} layer_e;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FINISH} state_e;

  function automatic logic [ROW_CW-1:0] rows_of(input layer_e l);
    return (l == L_OUT) ? ROW_CW'(NUM_NEURONS) : ROW_CW'(IMG_SZ);
  endfunction

  function automatic logic [BEAT_CW-1:0] last_beat_of(input layer_e l);
    return (l == L_OUT) ? BEAT_CW'(BEATS1 - 1) : BEAT_CW'(BEATS0 - 1);
  endfunction

endpackage

// File: rtl/row_fifo2.sv
// Two-entry FIFO of complete weight rows. Storage is unreset; only pointers and
// the occupancy count are reset or flushed.
module row_fifo2
  import weight_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  row_t       push_data,
  input  logic       pop,
  output row_t       head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  row_t       mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(push_ok) - 2'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/weight_streamer.sv
// Streams layer weight rows from the weight SRAM to the neuron array: issues
// word reads, assembles rows from returning beats and buffers up to two rows.
module weight_streamer
  import weight_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int L0_BASE = 0,
  parameter int L1_BASE = 12544
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              row_valid,
  input  logic              row_take,
  output logic [ROW_W-1:0]  row_data,
  output logic [IDX_W-1:0]  row_idx,
  output logic              row_last,
  output logic              layer,
  output logic              busy,
  output logic              done
);

  state_e               state_reg, state_next;
  layer_e               layer_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [ROW_CW-1:0]    issue_row_reg;
  logic [BEAT_CW-1:0]   issue_beat_reg;
  logic [BEAT_CW-1:0]   ret_beat_reg;
  logic [ROW_CW-1:0]    take_cnt_reg;
  logic [1:0]           inflight_reg;
  logic                 rd_pending_reg;
  row_t                 asm_reg;

  row_t                 row_new;
  row_t                 row_push;
  row_t                 fifo_head;
  logic [1:0]           fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ROW_CW-1:0]    rows_total;
  logic [BEAT_CW-1:0]   last_beat;
  logic [2:0]           owned;
  logic                 capture;
  logic                 push;
  logic                 pop;
  logic                 issue_start;
  logic                 start;

  assign rows_total  = rows_of(layer_reg);
  assign last_beat   = last_beat_of(layer_reg);
  assign start       = (state_reg == S_IDLE) && (req0 || req1);
  assign capture     = (state_reg == S_STREAM) && rd_pending_reg;
  assign push        = capture && (ret_beat_reg == last_beat) && !abort && !fifo_full;
  assign row_valid   = !fifo_empty;
  assign pop         = (state_reg == S_STREAM) && row_valid && row_take && !abort;
  assign owned       = {1'b0, fifo_count} + {1'b0, inflight_reg};

  // A row already being issued always completes; a new row starts only while
  // buffered plus assembling rows leave room, so returning data always fits.
  assign mem_rd      = (state_reg == S_STREAM) && (issue_row_reg != rows_total) &&
                       ((issue_beat_reg != '0) || (owned < 3'd2));
  assign issue_start = mem_rd && (issue_beat_reg == '0);

  assign mem_addr  = mem_rd ? addr_reg : '0;
  assign row_data  = row_valid ? fifo_head : '0;
  assign row_idx   = row_valid ? take_cnt_reg[IDX_W-1:0] : '0;
  assign row_last  = row_valid && (take_cnt_reg == rows_total - 1'b1);
  assign layer     = (layer_reg == L_OUT);
  assign busy      = (state_reg == S_STREAM);
  assign done      = (state_reg == S_FINISH);

  for (genvar gi = 0; gi < BEATS0; gi++) begin : g_beat
    assign row_new[gi*BEAT_W +: BEAT_W] = (ret_beat_reg == BEAT_CW'(gi)) ?
                                          mem_rdata : asm_reg[gi*BEAT_W +: BEAT_W];
  end

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_word
    if (gi < OUTPUT_SZ) begin : g_keep
      assign row_push[gi*32 +: 32] = row_new[gi*32 +: 32];
    end else begin : g_mask
      assign row_push[gi*32 +: 32] = (layer_reg == L_OUT) ? 32'd0 : row_new[gi*32 +: 32];
    end
  end

  row_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort && (state_reg != S_IDLE)),
    .push      (push),
    .push_data (row_push),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (req0 || req1) state_next = S_STREAM;
      S_STREAM: begin
        if (abort)                 state_next = S_IDLE;
        else if (pop && row_last)  state_next = S_FINISH;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_reg      <= L_HID;
      addr_reg       <= '0;
      issue_row_reg  <= '0;
      issue_beat_reg <= '0;
      ret_beat_reg   <= '0;
      take_cnt_reg   <= '0;
      inflight_reg   <= '0;
      rd_pending_reg <= 1'b0;
    end else if (state_reg == S_IDLE) begin
      rd_pending_reg <= 1'b0;
      if (start) begin
        layer_reg      <= req0 ? L_HID : L_OUT;
        addr_reg       <= req0 ? ADDR_W'(L0_BASE) : ADDR_W'(L1_BASE);
        issue_row_reg  <= '0;
        issue_beat_reg <= '0;
        ret_beat_reg   <= '0;
        take_cnt_reg   <= '0;
        inflight_reg   <= '0;
      end
    end else begin
      // Reads outstanding at an abort are forgotten, so their data is dropped.
      rd_pending_reg <= mem_rd && !abort;
      inflight_reg   <= inflight_reg + 2'(issue_start) - 2'(push);
      if (mem_rd) begin
        addr_reg <= addr_reg + 1'b1;
        if (issue_beat_reg == last_beat) begin
          issue_beat_reg <= '0;
          issue_row_reg  <= issue_row_reg + 1'b1;
        end else begin
          issue_beat_reg <= issue_beat_reg + 1'b1;
        end
      end
      if (capture) begin
        ret_beat_reg <= (ret_beat_reg == last_beat) ? '0 : ret_beat_reg + 1'b1;
      end
      if (pop) take_cnt_reg <= take_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) asm_reg <= row_new;
  end

endmodule

// File: tb/tb_weight_streamer.sv
// Randomized bench for weight_streamer: an SRAM model with a salted address
// pattern, and a row-level reference computing each expected weight word.
module tb_weight_streamer;
  import weight_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int L0_BASE = 0;
  localparam int L1_BASE = 12544;

  logic              clk;
  logic              rst_n;
  logic              req0;
  logic              req1;
  logic              abort;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_rdata;
  logic              row_valid;
  logic              row_take;
  logic [ROW_W-1:0]  row_data;
  logic [IDX_W-1:0]  row_idx;
  logic              row_last;
  logic              layer;
  logic              busy;
  logic              done;

  int          n_vec;
  int          n_err;
  logic [31:0] salt;

  weight_streamer #(.ADDR_W(ADDR_W), .L0_BASE(L0_BASE), .L1_BASE(L1_BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .abort     (abort),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .row_valid (row_valid),
    .row_take  (row_take),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .layer     (layer),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input int a, input int j);
    return {salt[7:0], 8'(j), 16'(a)};
  endfunction

  // Expected word k of row r: the lane of the SRAM word holding it, or zero
  // for layer-1 words past the output width.
  function automatic logic [31:0] exp_word(input bit lay, input int r, input int k);
    int beats;
    int base;
    beats = lay ? BEATS1 : BEATS0;
    base  = lay ? L1_BASE : L0_BASE;
    if (lay && k >= OUTPUT_SZ) return 32'd0;
    return data_of(base + r * beats + k / LANES, k % LANES);
  endfunction

  // SRAM with one-cycle read latency; idle cycles return junk.
  always @(posedge clk) begin
    for (int j = 0; j < LANES; j++)
      mem_rdata[j*32 +: 32] <= mem_rd ? data_of(int'(mem_addr), j) : $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input bit lay, input int pct, input bit both, input int abort_read);
    int beats;
    int total;
    int base;
    int c;
    int nreads;
    int exp_r;
    int bad;
    bit seen_rd;
    bit seen_vld;
    bit done_seen;
    bit aborted;
    beats = lay ? BEATS1 : BEATS0;
    total = lay ? NUM_NEURONS : IMG_SZ;
    base  = lay ? L1_BASE : L0_BASE;
    salt  = $urandom;
    req0  = !lay || both;
    req1  = lay || both;
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    c = 1; nreads = 0; exp_r = 0;
    seen_rd = 0; seen_vld = 0; done_seen = 0; aborted = 0;
    while (c < 20000 && !done_seen && !aborted) begin
      row_take = 1'b0;
      abort    = 1'b0;
      if (done) begin
        done_seen = 1;
        if (pct == 100) check_eq("done_cycle", c, beats + 2 + beats * (total - 1) + 1);
      end else begin
        if (mem_rd) begin
          if (!seen_rd) begin
            seen_rd = 1;
            check_eq("first_rd_cycle", c, 1);
          end
          check_eq("mem_addr", mem_addr, base + nreads);
          if (nreads == abort_read) begin
            abort   = 1'b1;
            aborted = 1;
          end
          nreads++;
        end
        if (row_valid && !seen_vld) begin
          seen_vld = 1;
          check_eq("first_row_cycle", c, beats + 2);
          check_eq("layer", layer, lay);
        end
        if (!aborted) begin
          if (both && c == 40) req1 = 1'b1;
          if (both && c == 41) req1 = 1'b0;
          row_take = ($urandom_range(99) < pct);
          if (row_take && row_valid) begin
            check_eq("row_idx", row_idx, exp_r);
            check_eq("row_last", row_last, exp_r == total - 1);
            bad = 0;
            for (int k = NUM_NEURONS - 1; k >= 0; k--)
              if (row_data[k*32 +: 32] !== exp_word(lay, exp_r, k)) bad = k;
            check_eq("row_word", row_data[bad*32 +: 32], exp_word(lay, exp_r, bad));
            exp_r++;
          end
        end
      end
      if (!done_seen) begin
        tick();
        c++;
      end
    end
    row_take = 1'b0;
    if (aborted) begin
      abort = 1'b0;
      check_eq("abort_row_valid", row_valid, 0);
      check_eq("abort_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
        check_eq("abort_no_done", done, 0);
        check_eq("abort_no_rd", mem_rd, 0);
        tick();
      end
    end else begin
      check_eq("done_seen", done_seen, 1);
      check_eq("rows_taken", exp_r, total);
      check_eq("reads_total", nreads, total * beats);
      tick();
      check_eq("done_pulse_len", done, 0);
      check_eq("busy_after", busy, 0);
      check_eq("valid_after", row_valid, 0);
    end
  endtask

  task automatic backpressure();
    int nr;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    row_take = 1'b0;
    nr = 0;
    for (int i = 0; i < 60; i++) begin
      if (mem_rd) nr++;
      tick();
    end
    check_eq("bp_reads", nr, 2 * BEATS0);
    check_eq("bp_stall_rd", mem_rd, 0);
    check_eq("bp_valid", row_valid, 1);
    check_eq("bp_idx0", row_idx, 0);
    row_take = 1'b1;
    if (mem_rd) nr++;
    tick();
    row_take = 1'b0;
    check_eq("bp_idx1", row_idx, 1);
    for (int i = 0; i < 40; i++) begin
      if (mem_rd) nr++;
      tick();
    end
    check_eq("bp_reads_more", nr, 3 * BEATS0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("bp_abort_busy", busy, 0);
    check_eq("bp_abort_valid", row_valid, 0);
    tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0; salt = 32'd0;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; abort = 1'b0; row_take = 1'b0;
    repeat (3) tick();
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_valid", row_valid, 0);
    check_eq("rst_row_data", |row_data, 0);
    check_eq("rst_row_idx", row_idx, 0);
    check_eq("rst_outs", {row_last, layer, busy, done}, 0);
    req0 = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_idle", {mem_rd, busy}, 0);

    run_stream(1'b0, 100, 1'b0, -1);
    run_stream(1'b1, 100, 1'b0, -1);
    run_stream(1'b1, 40, 1'b0, -1);
    backpressure();
    run_stream(1'b0, 70, 1'b1, 5 * BEATS0 + 3);
    run_stream(1'b0, 60, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
